seg_scroll_scheduler: RTL and testbench
=======================================

# seg_scroll_scheduler

Sequencer for the board's 4-digit, active-low, common-anode seven-segment display. It time-multiplexes the four anodes and scrolls a fixed 17-character message ("UABC-ELECTRONICA" behind a leading blank) right-to-left across the 4-digit window. Software or a button front-end starts and stops it through a start/stop/busy/done handshake. It drives the `seg`/`an` pins directly and replaces the free-running single-digit letter sequencer.

## Interface
- `REFRESH_DIV`, default 5000: clk cycles per digit slot; legal range ≥2.
- `SCROLL_FRAMES`, default 50: full 4-digit frames per scroll step; legal range ≥1.
- `MSG_LEN`, default 17: message length in characters, including the leading blank at index 0.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a scroll pass; sampled only in IDLE.
- `stop`  in  1  abort request; sampled every cycle.
- `repeat_en`  in  1  when 1, the pass restarts from position 0 instead of finishing; sampled at the end of each pass.
- `busy`  out  1  high while state = RUN.
- `done`  out  1  one-cycle pulse when a pass completes naturally.
- `seg`  out  7  segment pattern, {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit enables, active-low; `an[0]` is the rightmost digit.

Clock is `clk`; reset is `rst`, synchronous and active-high. Reset values: `seg`=7'b1111111, `an`=4'b1111, `busy`=0, `done`=0, state=IDLE, and all counters 0.

## Operation
- States: IDLE and RUN.
  - IDLE → RUN on `start`=1 & `stop`=0.
  - RUN → IDLE on `stop`, or on pass end with `repeat_en`=0.
  - If `start` and `stop` arrive in the same cycle in IDLE, `stop` wins and the block stays in IDLE.
- Counters:
  - `div` runs 0..REFRESH_DIV-1. Its wrap is a slot tick.
  - `dig` runs 0..3 and advances on each slot tick.
  - `frm` runs 0..SCROLL_FRAMES-1 and advances on a slot tick when `dig`=3.
  - `pos` runs 0..MSG_LEN+3 and advances when `frm` wraps.
- Display rule: digit `d` shows the character at index `pos-d`. If `pos-d` is <0 or ≥MSG_LEN, the digit shows blank (7'b1111111). Index arithmetic is signed, 6 bits.
- Drive: `an` is all ones except `an[dig]`=0. `seg` = glyph(`pos-dig`). Both are registered and change in the same cycle.
- Pass end is the step boundary at which `pos`=MSG_LEN+3 would increment.
  - `repeat_en`=1: `pos` goes to 0 and RUN continues with no `done`.
  - `repeat_en`=0: `done`=1 for one cycle, then IDLE.
- Glyphs for indices 0..16: blank, U 1000001, A 0001000, b 0000011, C 1000110, - 0111111, E 0000110, L 1000111, E, C, t 1001110, r 0101111, o 1000000, n 0101011, I 1001111, C, A.
- In IDLE: `an`=4'b1111, `seg`=7'b1111111, all counters held at 0.
- `stop` mid-pass: counters clear and outputs blank on the next edge. `done` is not pulsed.
- `start` while in RUN is ignored.
- `rst` mid-pass behaves like `stop`, but also forces `done`=0.

## Timing
- `start` sampled at edge t: `busy`=1, `an`=4'b1110, `seg`=blank (pos 0, digit 0) from t+1.
- Each digit slot lasts REFRESH_DIV cycles, a frame lasts 4·REFRESH_DIV cycles, and a step lasts SCROLL_FRAMES·4·REFRESH_DIV cycles.
- One non-repeating pass keeps `busy` high for exactly (MSG_LEN+4)·SCROLL_FRAMES·4·REFRESH_DIV cycles.
- `done` is high in the first cycle with `busy`=0.
- `stop` sampled at edge t: `busy`=0, `an`=4'b1111 from t+1.
- No combinational path from the inputs to `seg`, `an`, `busy` or `done`.

## Structure
- Shared package `seg_disp_pkg`:
  - state enum (IDLE, RUN).
  - `SEG_BLANK`=7'b1111111 and the per-letter glyph constants.
  - `AN_OFF`=4'b1111.
- Sub-module `seg_glyph_rom`: combinational, 5-bit character index → 7-bit glyph. Any index outside 0..16 maps to `SEG_BLANK`. It is reused by the other display blocks.
- Counters, the FSM and the output registers live in `seg_scroll_scheduler`.

## Test plan
Unless stated otherwise: REFRESH_DIV=4, SCROLL_FRAMES=2, MSG_LEN=17.
1. Reset, then idle 100 cycles → `an`=1111, `seg`=1111111, `busy`=0, `done`=0 throughout.
2. `start` pulse at cycle 10 →
   - `busy`=1 from 11, `an` sequence 1110,1101,1011,0111 every 4 cycles.
   - At pos 4, digits 0..3 show C,b,A,U, i.e. `seg` 1000110, 0000011, 0001000, 1000001.
3. Full pass with `repeat_en`=0 → `busy` high for exactly 672 cycles, single-cycle `done`, then `an`=1111.
4. `repeat_en`=1 → no `done`, `pos` wraps 20→0, and `an`=1110 with blank `seg` immediately after the wrap.
5. `stop` at cycle 200 mid-pass → `busy`=0 and `an`=1111 at 201, no `done`. A `start` at 205 restarts from pos 0.
6. Edge cases:
   - `start`&`stop` together in IDLE → stays IDLE.
   - `start` pulsed during RUN → timing unchanged.
   - `rst` during RUN → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared seven-segment display types and glyph constants
package seg_disp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Glyphs are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_U   = 7'b1000001;
    localparam logic [6:0] GLYPH_A   = 7'b0001000;
    localparam logic [6:0] GLYPH_B   = 7'b0000011;
    localparam logic [6:0] GLYPH_C   = 7'b1000110;
    localparam logic [6:0] GLYPH_DSH = 7'b0111111;
    localparam logic [6:0] GLYPH_E   = 7'b0000110;
    localparam logic [6:0] GLYPH_L   = 7'b1000111;
    localparam logic [6:0] GLYPH_T   = 7'b1001110;
    localparam logic [6:0] GLYPH_R   = 7'b0101111;
    localparam logic [6:0] GLYPH_O   = 7'b1000000;
    localparam logic [6:0] GLYPH_N   = 7'b0101011;
    localparam logic [6:0] GLYPH_I   = 7'b1001111;

    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seg_glyph_rom.sv
// rtl/seg_glyph_rom.sv - character index to glyph lookup for the scrolling message
module seg_glyph_rom
    import seg_disp_pkg::*;
(
    input  logic [4:0] idx,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (idx)
            5'd1:    glyph = GLYPH_U;
            5'd2:    glyph = GLYPH_A;
            5'd3:    glyph = GLYPH_B;
            5'd4:    glyph = GLYPH_C;
            5'd5:    glyph = GLYPH_DSH;
            5'd6:    glyph = GLYPH_E;
            5'd7:    glyph = GLYPH_L;
            5'd8:    glyph = GLYPH_E;
            5'd9:    glyph = GLYPH_C;
            5'd10:   glyph = GLYPH_T;
            5'd11:   glyph = GLYPH_R;
            5'd12:   glyph = GLYPH_O;
            5'd13:   glyph = GLYPH_N;
            5'd14:   glyph = GLYPH_I;
            5'd15:   glyph = GLYPH_C;
            5'd16:   glyph = GLYPH_A;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scroll_scheduler.sv
// rtl/seg_scroll_scheduler.sv - multiplexes four anodes and scrolls the message with start/stop control
module seg_scroll_scheduler
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 5000,
    parameter int SCROLL_FRAMES = 50,
    parameter int MSG_LEN       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       repeat_en,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int FRM_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SCROLL_FRAMES - 1);
    localparam logic [5:0]       POS_LAST = 6'(MSG_LEN + 3);
    localparam logic signed [5:0] MSG_LEN_S = 6'(MSG_LEN);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       dig_q, dig_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic [5:0]       pos_q, pos_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             slot_tick, frame_end, step_end;
    logic signed [5:0] char_idx;
    logic [6:0]       rom_glyph;

    seg_glyph_rom u_rom (
        .idx   (char_idx[4:0]),
        .glyph (rom_glyph)
    );

    assign slot_tick = (div_q == DIV_LAST);
    assign frame_end = slot_tick && (dig_q == 2'd3);
    assign step_end  = frame_end && (frm_q == FRM_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dig_d   = dig_q;
        frm_d   = frm_q;
        pos_d   = pos_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    div_d = slot_tick ? '0 : div_q + 1'b1;
                    if (slot_tick) dig_d = dig_q + 2'd1;
                    if (frame_end) frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + 1'b1;
                    if (step_end) begin
                        if (pos_q != POS_LAST) begin
                            pos_d = pos_q + 6'd1;
                        end else if (repeat_en) begin
                            pos_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != ST_RUN) begin
            div_d = '0;
            dig_d = '0;
            frm_d = '0;
            pos_d = '0;
        end

        // Outputs follow the next counter values so seg/an line up with the slot that starts now.
        char_idx = $signed(pos_d) - $signed({4'b0000, dig_d});
        busy_d   = (state_d == ST_RUN);
        if (busy_d) begin
            an_d  = ~(4'b0001 << dig_d);
            seg_d = (char_idx[5] || (char_idx >= MSG_LEN_S)) ? SEG_BLANK : rom_glyph;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            dig_q   <= '0;
            frm_q   <= '0;
            pos_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dig_q   <= dig_d;
            frm_q   <= frm_d;
            pos_q   <= pos_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_seg_scroll_scheduler.sv
// tb/tb_seg_scroll_scheduler.sv - directed self-checking bench for the scrolling display sequencer
module tb_seg_scroll_scheduler;

    localparam int RD = 4;
    localparam int SF = 2;
    localparam int ML = 17;
    localparam int PASS_CYCLES = (ML + 4) * SF * 4 * RD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       repeat_en = 1'b0;
    logic       busy, done;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;
    int elapsed = 0;
    int done_cnt = 0;

    seg_scroll_scheduler #(
        .REFRESH_DIV   (RD),
        .SCROLL_FRAMES (SF),
        .MSG_LEN       (ML)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .repeat_en (repeat_en),
        .busy      (busy),
        .done      (done),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    typedef struct {
        int         pos;
        int         dig;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        elapsed++;
    endtask

    task automatic adv_to(input int target);
        while (elapsed < target) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        elapsed = 0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    function automatic logic [15:0] outs();
        return {3'b000, busy, done, an, seg};
    endfunction

    function automatic logic [15:0] idle_outs();
        return {3'b000, 1'b0, 1'b0, 4'b1111, 7'b1111111};
    endfunction

    initial begin
        int cnt;
        int d0;

        vecs[0]  = '{0,  0, 4'b1110, 7'b1111111};
        vecs[1]  = '{0,  1, 4'b1101, 7'b1111111};
        vecs[2]  = '{0,  2, 4'b1011, 7'b1111111};
        vecs[3]  = '{0,  3, 4'b0111, 7'b1111111};
        vecs[4]  = '{1,  0, 4'b1110, 7'b1000001};
        vecs[5]  = '{1,  1, 4'b1101, 7'b1111111};
        vecs[6]  = '{4,  0, 4'b1110, 7'b1000110};
        vecs[7]  = '{4,  1, 4'b1101, 7'b0000011};
        vecs[8]  = '{4,  2, 4'b1011, 7'b0001000};
        vecs[9]  = '{4,  3, 4'b0111, 7'b1000001};
        vecs[10] = '{10, 0, 4'b1110, 7'b1001110};
        vecs[11] = '{10, 3, 4'b0111, 7'b1000111};
        vecs[12] = '{17, 1, 4'b1101, 7'b0001000};
        vecs[13] = '{20, 3, 4'b0111, 7'b1111111};

        // Reset and idle
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle", outs(), idle_outs());
        end

        // Display vectors across one pass, sampled mid-slot of the first frame of each step
        do_start();
        check("start_first", outs(), {3'b000, 1'b1, 1'b0, 4'b1110, 7'b1111111});
        for (int i = 0; i < 14; i++) begin
            adv_to((vecs[i].pos * SF * 4 + vecs[i].dig) * RD + 2);
            check($sformatf("vec%0d", i), outs(), {3'b000, 1'b1, 1'b0, vecs[i].an, vecs[i].seg});
        end
        adv_to(PASS_CYCLES + 4);

        // Full pass length and done pulse
        d0 = done_cnt;
        do_start();
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            step();
        end
        check("busy_len", 16'(cnt), 16'(PASS_CYCLES));
        check("done_first_idle", 16'(done), 16'd1);
        check("done_none_early", 16'(done_cnt - d0), 16'd0);
        step();
        check("after_done", outs(), idle_outs());
        check("done_single", 16'(done_cnt - d0), 16'd1);

        // Repeat mode wraps pos 20 -> 0 with no done
        repeat_en = 1'b1;
        d0 = done_cnt;
        do_start();
        adv_to(PASS_CYCLES - 1);
        check("rep_last", outs(), {3'b000, 1'b1, 1'b0, 4'b0111, 7'b1111111});
        adv_to(PASS_CYCLES);
        check("rep_wrap", outs(), {3'b000, 1'b1, 1'b0, 4'b1110, 7'b1111111});
        adv_to(PASS_CYCLES + SF * 4 * RD + 2);
        check("rep_pos1", outs(), {3'b000, 1'b1, 1'b0, 4'b1110, 7'b1000001});
        do_stop();
        check("rep_stop", outs(), idle_outs());
        check("rep_no_done", 16'(done_cnt - d0), 16'd0);
        repeat_en = 1'b0;

        // Stop mid-pass, then restart from pos 0
        d0 = done_cnt;
        do_start();
        adv_to(189);
        do_stop();
        check("stop_mid", outs(), idle_outs());
        repeat (3) step();
        check("stop_hold", outs(), idle_outs());
        do_start();
        check("restart", outs(), {3'b000, 1'b1, 1'b0, 4'b1110, 7'b1111111});
        adv_to(SF * 4 * RD + 2);
        check("restart_pos1", outs(), {3'b000, 1'b1, 1'b0, 4'b1110, 7'b1000001});
        do_stop();
        check("stop_no_done", 16'(done_cnt - d0), 16'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", outs(), idle_outs());
        step();
        check("start_stop_hold", outs(), idle_outs());

        // start during RUN does not disturb timing
        do_start();
        adv_to(50);
        start = 1'b1;
        step();
        start = 1'b0;
        adv_to(4 * SF * 4 * RD + 2);
        check("rerun_pos4", outs(), {3'b000, 1'b1, 1'b0, 4'b1110, 7'b1000110});
        adv_to(PASS_CYCLES - 1);
        check("rerun_busy_end", 16'(busy), 16'd1);
        adv_to(PASS_CYCLES);
        check("rerun_done", {14'd0, busy, done}, 16'b01);
        step();

        // rst on the final edge of a pass suppresses done
        d0 = done_cnt;
        do_start();
        adv_to(PASS_CYCLES - 1);
        rst = 1'b1;
        step();
        check("rst_run", outs(), idle_outs());
        rst = 1'b0;
        step();
        check("rst_hold", outs(), idle_outs());
        check("rst_no_done", 16'(done_cnt - d0), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
